// File: rtl/gecko_test_pkg.sv
// Shared types for the Gecko test supervisor: verdict encoding and
// fault-index helpers used by the monitor and its bench.
package gecko_test_pkg;

  typedef enum logic [1:0] {
    RUNNING   = 2'd0,
    PASSED    = 2'd1,
    FAILED    = 2'd2,
    TIMED_OUT = 2'd3
  } gecko_test_state_t;

  localparam int MAX_CORES       = 32;
  localparam int MAX_FAULT_IDX_W = $clog2(MAX_CORES);

  // Widest first_fault value: MSB is the valid bit, the rest the core index.
  typedef logic [MAX_FAULT_IDX_W:0] gecko_test_fault_index_t;

  // Index field width for n cores; a single core still needs one bit.
  function automatic int fault_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gecko_priority_encoder.sv
// Lowest-set-bit priority encoder with a valid flag.
module gecko_priority_encoder
  import gecko_test_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = fault_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gecko_test_monitor.sv
// Multi-core test supervisor: sticky finish/fault masks, run cycle count,
// watchdog, and a single terminal verdict that holds until rst or clear.
module gecko_test_monitor
  import gecko_test_pkg::*;
#(
  parameter int NUM_CORES      = 1,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [NUM_CORES-1:0]         faulted,
  input  logic [NUM_CORES-1:0]         finished,
  output gecko_test_state_t            state,
  output logic                         done,
  output logic [NUM_CORES-1:0]         finished_mask,
  output logic [NUM_CORES-1:0]         faulted_mask,
  output logic [$clog2(NUM_CORES):0]   first_fault,
  output logic [COUNT_WIDTH-1:0]       cycle_count
);

  localparam int FF_W = $clog2(NUM_CORES) + 1;
  // Count value seen on the edge that completes the watchdog window.
  localparam logic [COUNT_WIDTH-1:0] LAST_RUN_CNT =
    (TIMEOUT_CYCLES == 0) ? '0 : COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  gecko_test_state_t      state_d, state_q;
  logic                   done_d, done_q;
  logic [NUM_CORES-1:0]   fin_mask_d, fin_mask_q, fin_upd;
  logic [NUM_CORES-1:0]   flt_mask_d, flt_mask_q, flt_upd;
  logic [FF_W-1:0]        first_fault_d, first_fault_q, flt_enc;
  logic [COUNT_WIDTH-1:0] cnt_d, cnt_q, cnt_inc;

  generate
    if (NUM_CORES == 1) begin : g_single
      assign flt_enc = faulted;
    end else begin : g_multi
      logic [FF_W-2:0] enc_idx;
      logic            enc_valid;
      gecko_priority_encoder #(.WIDTH(NUM_CORES), .IDX_W(FF_W - 1)) u_enc (
        .req   (faulted),
        .idx   (enc_idx),
        .valid (enc_valid)
      );
      assign flt_enc = {enc_valid, enc_idx};
    end
  endgenerate

  always_comb begin
    fin_upd       = fin_mask_q | finished;
    flt_upd       = flt_mask_q | faulted;
    cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    state_d       = state_q;
    fin_mask_d    = fin_mask_q;
    flt_mask_d    = flt_mask_q;
    first_fault_d = first_fault_q;
    cnt_d         = cnt_q;
    if (clear) begin
      state_d       = RUNNING;
      fin_mask_d    = '0;
      flt_mask_d    = '0;
      first_fault_d = '0;
      cnt_d         = '0;
    end else if (state_q == RUNNING) begin
      fin_mask_d = fin_upd;
      flt_mask_d = flt_upd;
      cnt_d      = cnt_inc;
      // Fault beats finish beats watchdog when they land on the same edge.
      if (|flt_upd) begin
        state_d = FAILED;
        if (!first_fault_q[FF_W-1]) first_fault_d = flt_enc;
      end else if (&fin_upd) begin
        state_d = PASSED;
      end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == LAST_RUN_CNT)) begin
        state_d = TIMED_OUT;
      end
    end
    done_d = (state_d != RUNNING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUNNING;
      done_q        <= 1'b0;
      fin_mask_q    <= '0;
      flt_mask_q    <= '0;
      first_fault_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      fin_mask_q    <= fin_mask_d;
      flt_mask_q    <= flt_mask_d;
      first_fault_q <= first_fault_d;
      cnt_q         <= cnt_d;
    end
  end

  assign state         = state_q;
  assign done          = done_q;
  assign finished_mask = fin_mask_q;
  assign faulted_mask  = flt_mask_q;
  assign first_fault   = first_fault_q;
  assign cycle_count   = cnt_q;

endmodule

// File: tb/tb_gecko_test_monitor.sv
// Bench for gecko_test_monitor: a 4-core watchdog instance and a 1-core
// instance with the watchdog disabled and a narrow counter.
module tb_gecko_test_monitor;
  import gecko_test_pkg::*;

  int checks = 0;
  int errors = 0;

  // clock / reset
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 4 cores, watchdog 16, 8-bit counter
  logic              rst_a, clear_a;
  logic [3:0]        fin_a, flt_a;
  gecko_test_state_t st_a;
  logic              done_a;
  logic [3:0]        fmask_a, xmask_a;
  logic [2:0]        ff_a;
  logic [7:0]        cnt_a;

  gecko_test_monitor #(.NUM_CORES(4), .TIMEOUT_CYCLES(16), .COUNT_WIDTH(8)) u_dut_a (
    .clk           (clk),
    .rst           (rst_a),
    .clear         (clear_a),
    .faulted       (flt_a),
    .finished      (fin_a),
    .state         (st_a),
    .done          (done_a),
    .finished_mask (fmask_a),
    .faulted_mask  (xmask_a),
    .first_fault   (ff_a),
    .cycle_count   (cnt_a)
  );

  // DUT B: 1 core, watchdog off, 4-bit counter
  logic              rst_b, clear_b;
  logic [0:0]        fin_b, flt_b;
  gecko_test_state_t st_b;
  logic              done_b;
  logic [0:0]        fmask_b, xmask_b;
  logic [0:0]        ff_b;
  logic [3:0]        cnt_b;

  gecko_test_monitor #(.NUM_CORES(1), .TIMEOUT_CYCLES(0), .COUNT_WIDTH(4)) u_dut_b (
    .clk           (clk),
    .rst           (rst_b),
    .clear         (clear_b),
    .faulted       (flt_b),
    .finished      (fin_b),
    .state         (st_b),
    .done          (done_b),
    .finished_mask (fmask_b),
    .faulted_mask  (xmask_b),
    .first_fault   (ff_b),
    .cycle_count   (cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model for A: verdict as an int code, masks as plain sets,
  // count as an integer that counts RUNNING edges.
  int         ma_verdict;
  logic [3:0] ma_fin, ma_flt;
  int         ma_first;
  int         ma_cnt;

  task automatic model_a_reset();
    ma_verdict = 0; ma_fin = '0; ma_flt = '0; ma_first = -1; ma_cnt = 0;
  endtask

  task automatic model_a_edge(input logic [3:0] fin, input logic [3:0] flt, input logic clr);
    if (clr) begin
      model_a_reset();
    end else if (ma_verdict == 0) begin
      ma_fin = ma_fin | fin;
      ma_flt = ma_flt | flt;
      if (ma_cnt < 255) ma_cnt = ma_cnt + 1;
      if (ma_flt != 0) begin
        ma_verdict = 2;
        for (int i = 3; i >= 0; i--) if (flt[i]) ma_first = i;
      end else if (ma_fin == 4'hf) begin
        ma_verdict = 1;
      end else if (ma_cnt == 16) begin
        ma_verdict = 3;
      end
    end
  endtask

  task automatic check_a(input string tag);
    chk({tag, ".state"}, 32'(st_a), 32'(ma_verdict));
    chk({tag, ".done"}, 32'(done_a), (ma_verdict != 0) ? 32'd1 : 32'd0);
    chk({tag, ".fin_mask"}, 32'(fmask_a), 32'(ma_fin));
    chk({tag, ".flt_mask"}, 32'(xmask_a), 32'(ma_flt));
    chk({tag, ".first_fault"}, 32'(ff_a), (ma_first < 0) ? 32'd0 : 32'(4 + ma_first));
    chk({tag, ".count"}, 32'(cnt_a), 32'(ma_cnt));
  endtask

  // driver: apply inputs, advance one edge, sample 1 ns later
  task automatic cyc_a(input logic [3:0] fin, input logic [3:0] flt, input logic clr);
    fin_a = fin; flt_a = flt; clear_a = clr;
    model_a_edge(fin, flt, clr);
    @(posedge clk); #1;
    check_a("a");
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) cyc_a(4'h0, 4'h0, 1'b0);
  endtask

  // Reference model for B (single core, saturating 4-bit count)
  int mb_verdict, mb_cnt;
  logic mb_fin, mb_flt;

  task automatic cyc_b(input logic fin, input logic flt, input logic clr);
    fin_b = fin; flt_b = flt; clear_b = clr;
    if (clr) begin
      mb_verdict = 0; mb_cnt = 0; mb_fin = 0; mb_flt = 0;
    end else if (mb_verdict == 0) begin
      mb_fin = mb_fin | fin;
      mb_flt = mb_flt | flt;
      if (mb_cnt < 15) mb_cnt = mb_cnt + 1;
      if (mb_flt) mb_verdict = 2;
      else if (mb_fin) mb_verdict = 1;
    end
    @(posedge clk); #1;
    chk("b.state", 32'(st_b), 32'(mb_verdict));
    chk("b.count", 32'(cnt_b), 32'(mb_cnt));
    chk("b.first_fault", 32'(ff_b), 32'(mb_flt));
  endtask

  typedef struct {
    logic [3:0] fin;
    logic [3:0] flt;
    logic [1:0] exp_state;
    logic [7:0] exp_cnt;
    logic [3:0] exp_fmask;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Multi-core ordering: bits 2,0,3,1 finish on edges 3,5,7,9.
    for (int i = 0; i < 9; i++) begin
      tbl[i].fin       = 4'h0;
      tbl[i].flt       = 4'h0;
      tbl[i].exp_state = 2'd0;
      tbl[i].exp_cnt   = 8'(i + 1);
      tbl[i].exp_fmask = 4'h0;
    end
    tbl[2].fin = 4'b0100; tbl[4].fin = 4'b0001; tbl[6].fin = 4'b1000; tbl[8].fin = 4'b0010;
    tbl[2].exp_fmask = 4'b0100; tbl[3].exp_fmask = 4'b0100;
    tbl[4].exp_fmask = 4'b0101; tbl[5].exp_fmask = 4'b0101;
    tbl[6].exp_fmask = 4'b1101; tbl[7].exp_fmask = 4'b1101;
    tbl[8].exp_fmask = 4'b1111; tbl[8].exp_state = 2'd1;

    rst_a = 1'b1; clear_a = 1'b0; fin_a = '0; flt_a = '0;
    rst_b = 1'b1; clear_b = 1'b0; fin_b = '0; flt_b = '0;
    model_a_reset();
    mb_verdict = 0; mb_cnt = 0; mb_fin = 0; mb_flt = 0;
    @(posedge clk); @(posedge clk); #1;
    check_a("reset");
    rst_a = 1'b0;

    for (int i = 0; i < 9; i++) begin
      cyc_a(tbl[i].fin, tbl[i].flt, 1'b0);
      chk("tbl.state", 32'(st_a), 32'(tbl[i].exp_state));
      chk("tbl.count", 32'(cnt_a), 32'(tbl[i].exp_cnt));
      chk("tbl.fin_mask", 32'(fmask_a), 32'(tbl[i].exp_fmask));
    end
    cyc_a(4'hf, 4'hf, 1'b0);
    chk("passed_frozen.state", 32'(st_a), 32'(PASSED));
    chk("passed_frozen.count", 32'(cnt_a), 32'd9);

    // Simultaneous faults on edge 6, then a late fault on core 0
    cyc_a(4'h0, 4'h0, 1'b1);
    idle_a(5);
    cyc_a(4'h0, 4'b1010, 1'b0);
    chk("sim_fault.state", 32'(st_a), 32'(FAILED));
    chk("sim_fault.first", 32'(ff_a), 32'b101);
    chk("sim_fault.mask", 32'(xmask_a), 32'b1010);
    cyc_a(4'h0, 4'b0001, 1'b0);
    chk("late_fault.first", 32'(ff_a), 32'b101);
    chk("late_fault.mask", 32'(xmask_a), 32'b1010);
    chk("late_fault.count", 32'(cnt_a), 32'd6);

    // Clear wins over a fault in the same cycle
    cyc_a(4'h0, 4'b0001, 1'b1);
    chk("clear.state", 32'(st_a), 32'(RUNNING));
    chk("clear.masks", 32'({fmask_a, xmask_a}), 32'd0);
    chk("clear.count", 32'(cnt_a), 32'd0);

    // Watchdog, then the two tie-breaks on edge 16
    idle_a(16);
    chk("wdog.state", 32'(st_a), 32'(TIMED_OUT));
    chk("wdog.count", 32'(cnt_a), 32'd16);
    cyc_a(4'h0, 4'h0, 1'b1);
    idle_a(15);
    cyc_a(4'h0, 4'b0100, 1'b0);
    chk("tie_fault.state", 32'(st_a), 32'(FAILED));
    chk("tie_fault.first", 32'(ff_a), 32'b110);
    cyc_a(4'h0, 4'h0, 1'b1);
    for (int e = 1; e <= 15; e++)
      cyc_a((e == 2) ? 4'b0001 : (e == 4) ? 4'b0010 : (e == 6) ? 4'b0100 : 4'h0, 4'h0, 1'b0);
    cyc_a(4'b1000, 4'h0, 1'b0);
    chk("tie_pass.state", 32'(st_a), 32'(PASSED));
    chk("tie_pass.count", 32'(cnt_a), 32'd16);

    // Async reset between edges
    cyc_a(4'h0, 4'h0, 1'b1);
    cyc_a(4'b0011, 4'h0, 1'b0);
    idle_a(3);
    #3 rst_a = 1'b1;
    #1;
    model_a_reset();
    check_a("async_rst");
    #1 rst_a = 1'b0;

    // Randomized runs against the model
    for (int run = 0; run < 30; run++) begin
      cyc_a(4'h0, 4'h0, 1'b1);
      for (int c = 0; c < 25; c++) begin
        logic [3:0] f, x;
        for (int b = 0; b < 4; b++) begin
          f[b] = ($urandom_range(0, 5) == 0);
          x[b] = ($urandom_range(0, 39) == 0);
        end
        cyc_a(f, x, $urandom_range(0, 39) == 0);
      end
    end

    // DUT B: single-core pass on edge 10, then saturation with watchdog off
    rst_b = 1'b0;
    for (int e = 1; e <= 9; e++) cyc_b(1'b0, 1'b0, 1'b0);
    cyc_b(1'b1, 1'b0, 1'b0);
    chk("single.state", 32'(st_b), 32'(PASSED));
    chk("single.done", 32'(done_b), 32'd1);
    chk("single.count", 32'(cnt_b), 32'd10);
    chk("single.mask", 32'(fmask_b), 32'd1);
    cyc_b(1'b0, 1'b1, 1'b0);
    chk("single.frozen_fault", 32'(xmask_b), 32'd0);
    cyc_b(1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 40; e++) cyc_b(1'b0, 1'b0, 1'b0);
    chk("nowdog.state", 32'(st_b), 32'(RUNNING));
    chk("nowdog.done", 32'(done_b), 32'd0);
    chk("nowdog.count", 32'(cnt_b), 32'd15);
    cyc_b(1'b1, 1'b1, 1'b0);
    chk("single_both.state", 32'(st_b), 32'(FAILED));
    chk("single_both.first", 32'(ff_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gecko_test_monitor.md
# gecko_test_monitor

Parametrised simulation/FPGA test supervisor for Gecko cores. It collects `faulted`/`finished` flags from up to `NUM_CORES` cores, tracks which cores have finished or faulted, and measures run length. It declares a single verdict: pass, fail, or timeout. It sits beside one or more `gecko_micro` instances in a top-level wrapper and replaces the single-core, flag-only test wrapper. Over that wrapper it adds multi-core aggregation, a watchdog, a cycle count, and a restartable run.

## Interface
- `NUM_CORES`, 1, number of monitored cores (1..32)
- `TIMEOUT_CYCLES`, 1048576, watchdog limit in run cycles; 0 disables the watchdog
- `COUNT_WIDTH`, 32, width of `cycle_count`; must satisfy `2**COUNT_WIDTH > TIMEOUT_CYCLES`
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous restart of the run (same effect as reset)
- `faulted`  in  NUM_CORES  per-core fault flag, level, sampled every cycle
- `finished`  in  NUM_CORES  per-core finished flag, level, sampled every cycle
- `state`  out  2  `gecko_test_state_t`: RUNNING, PASSED, FAILED, TIMED_OUT
- `done`  out  1  high when `state != RUNNING`
- `finished_mask`  out  NUM_CORES  sticky: core has asserted `finished`
- `faulted_mask`  out  NUM_CORES  sticky: core has asserted `faulted`
- `first_fault`  out  $clog2(NUM_CORES)+1  index of first faulting core; MSB is the valid bit
- `cycle_count`  out  COUNT_WIDTH  rising edges spent in RUNNING

## Operation
- Reset (async) or `clear` (sync) sets every output as follows:
  - `state=RUNNING`, `done=0`
  - both masks 0, `first_fault=0`, `cycle_count=0`
- `clear` has priority over all other inputs in the same cycle.
- In RUNNING, each edge:
  - `finished_mask |= finished`
  - `faulted_mask |= faulted`
  - `cycle_count += 1`
- Transitions out of RUNNING are evaluated on the edge from the updated masks. Priority, highest first:
  1. Any bit of the updated `faulted_mask` set → FAILED.
     - `first_fault` captures the lowest-index core faulting this cycle.
     - `first_fault` is written once only and never overwritten.
  2. Updated `finished_mask` all-ones → PASSED.
  3. `TIMEOUT_CYCLES != 0` and `cycle_count == TIMEOUT_CYCLES-1` → TIMED_OUT.
- PASSED, FAILED and TIMED_OUT are terminal until `rst`/`clear`.
  - Masks and `cycle_count` freeze.
  - Later flag activity is ignored.
- A core that asserts both flags counts as faulted.
- Flags deasserting does not clear mask bits.
- `cycle_count` never wraps, because the watchdog parameter rule guarantees this. With the watchdog disabled, it saturates at all-ones.

## Timing
- Inputs are sampled on edge N; the resulting masks, state, and `cycle_count` are visible after edge N. Latency is 1 cycle from a flag to the verdict.
- Outputs are registered only; there are no combinational input-to-output paths.
- `cycle_count` on the edge that enters a terminal state includes that edge. The value read in the terminal state is the number of RUNNING edges, including the last.
  - Example: first edge after reset release with `finished` all-ones gives PASSED and `cycle_count=1`.
- Watchdog: with no flags, TIMED_OUT is reached after exactly `TIMEOUT_CYCLES` edges, with `cycle_count = TIMEOUT_CYCLES`.
- Fault on the same edge as the timeout edge → FAILED.
- Last finish on the same edge as the timeout edge → PASSED.
- `rst` mid-run clears all state immediately, without waiting for the clock.

## Structure
- Shared package `gecko_test_pkg` holds:
  - the `gecko_test_state_t` enum (2 bits: RUNNING=0, PASSED=1, FAILED=2, TIMED_OUT=3)
  - a `gecko_test_fault_index_t` typedef helper
- One sub-module: `gecko_priority_encoder` (parametrised width). It gives the lowest set index plus a valid bit and is used for `first_fault`.
- Upgrade of existing wrappers: instantiate with `NUM_CORES=1` and tie `clear=0`.

## Test plan
- **Single-core pass:** `NUM_CORES=1`; assert `finished` on cycle 10 after reset → after that edge: PASSED, `done=1`, `cycle_count=10`, `finished_mask=1`.
- **Multi-core ordering:** `NUM_CORES=4`; `finished` bits 2,0,3,1 on cycles 3,5,7,9, each pulsed for 1 cycle.
  - Stays RUNNING until cycle 9, then PASSED with `finished_mask=4'b1111` and `cycle_count=9`.
- **Simultaneous faults:** `NUM_CORES=4`; `faulted=4'b1010` on cycle 6 → FAILED, `first_fault` = valid with index 1, `faulted_mask=4'b1010`.
  - A later `faulted[0]` pulse leaves all outputs unchanged.
- **Watchdog and tie-break:**
  - `TIMEOUT_CYCLES=16`, no flags → TIMED_OUT after edge 16, `cycle_count=16`.
  - Rerun with a fault on edge 16 → FAILED.
  - Rerun with the last finish on edge 16 → PASSED.
- **Clear and reset:**
  - In FAILED, pulse `clear` together with `faulted=1` → RUNNING with all masks 0 and `cycle_count=0`.
  - Assert `rst` between clock edges mid-run → outputs reach their reset values before the next edge.
- **Watchdog disabled:** `TIMEOUT_CYCLES=0`, `COUNT_WIDTH=4`, no flags for 40 cycles → still RUNNING, `cycle_count` saturated at 15.
